// File: rtl/apb_master_bridge_n.sv
// APB master bridge: valid/ready single requests become APB SETUP/ENABLE transfers
// with a one-hot PSEL vector. Optional ENABLE wait timeout: define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge_n #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [DATA_W/8-1:0]     req_strb,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [NUM_SLAVES-1:0]   PSEL,
  output logic                    PENABLE,
  output logic [ADDR_W-1:0]       PADDR,
  output logic                    PWRITE,
  output logic [DATA_W-1:0]       PWDATA,
  output logic [DATA_W/8-1:0]     PSTRB,
  input  logic [DATA_W-1:0]       PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int SEL_W = $clog2(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, SETUP, ENABLE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_done;
  logic               w_timeout;
  logic [SEL_W-1:0]   w_sel_idx;

  assign req_ready = (r_state == IDLE) || ((r_state == ENABLE) && PREADY);
  assign w_accept  = req_valid && req_ready;
  assign w_done    = (r_state == ENABLE) && PREADY;
  assign w_sel_idx = PADDR[ADDR_W-1 -: SEL_W];
  assign PENABLE   = (r_state == ENABLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_wait_cnt;

  // Counter holds the wait cycles already seen, so this is the TIMEOUT-th one.
  assign w_timeout = (r_state == ENABLE) && !PREADY &&
                     (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)
      r_wait_cnt <= '0;
    else if (w_state_nxt == SETUP)
      r_wait_cnt <= '0;
    else if ((r_state == ENABLE) && !PREADY)
      r_wait_cnt <= r_wait_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ENABLE;
      ENABLE: begin
        if (w_done)         w_state_nxt = w_accept ? SETUP : IDLE;
        else if (w_timeout) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Select is decoded from state, so reset drops it without waiting for a clock.
  always_comb begin
    PSEL = '0;
    if (r_state != IDLE) PSEL[w_sel_idx] = 1'b1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (w_accept) begin
      PADDR  <= req_addr;
      PWRITE <= req_write;
      PWDATA <= req_wdata;
      PSTRB  <= req_write ? req_strb : '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= w_done || w_timeout;
      rsp_rdata <= (w_done && !PWRITE) ? PRDATA : '0;
      rsp_err   <= w_done ? PSLVERR : w_timeout;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge_n.sv
// Self-checking bench for apb_master_bridge_n: directed cases from the plan plus
// randomized single transfers checked against a transaction-level expectation.
module tb_apb_master_bridge_n;

  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 8;
  localparam int NUM_SLAVES = 2;
  localparam int TIMEOUT    = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid, req_ready, req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_strb;
  logic                  rsp_valid, rsp_err;
  logic [DATA_W-1:0]     rsp_rdata;
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable, pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata, prdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic                  pready, pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_master_bridge_n #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(clk), .PRESET(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
    .PWDATA(pwdata), .PSTRB(pstrb), .PRDATA(prdata), .PREADY(pready),
    .PSLVERR(pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, req);
    end
  endtask

  // Slave select expected from the top address bit (two slaves).
  function automatic logic [31:0] sel_of(input logic [ADDR_W-1:0] a);
    return 32'(1) << a[ADDR_W-1];
  endfunction

  // One complete transfer with 'waits' PREADY-low ENABLE cycles, no follow-on request.
  task automatic xfer(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                      input logic [DATA_W/8-1:0] ws, input int waits,
                      input logic [DATA_W-1:0] rd, input logic err, input string tag);
    logic [31:0] e_sel;
    e_sel = sel_of(a);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_strb = ws;
    #1 check({tag, ".ready_idle"}, 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = ADDR_W'($urandom); req_wdata = DATA_W'($urandom);
    check({tag, ".setup_psel"}, 32'(psel), e_sel);
    check({tag, ".setup_pen"}, 32'(penable), 0);
    check({tag, ".paddr"}, 32'(paddr), 32'(a));
    check({tag, ".pwrite"}, 32'(pwrite), 32'(wr));
    check({tag, ".pwdata"}, 32'(pwdata), 32'(wd));
    check({tag, ".pstrb"}, 32'(pstrb), wr ? 32'(ws) : 0);
    prdata = rd; pslverr = err;
    for (int e = 0; e <= waits; e++) begin
      @(negedge clk);
      pready = (e == waits);
      #1;
      check({tag, ".en_pen"}, 32'(penable), 1);
      check({tag, ".en_psel"}, 32'(psel), e_sel);
      check({tag, ".en_paddr"}, 32'(paddr), 32'(a));
      check({tag, ".en_ready"}, 32'(req_ready), 32'(e == waits));
      check({tag, ".en_rspv"}, 32'(rsp_valid), 0);
    end
    @(negedge clk);
    pready = 1'b0;
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 1);
    check({tag, ".rsp_err"}, 32'(rsp_err), 32'(err));
    check({tag, ".rsp_rdata"}, 32'(rsp_rdata), wr ? 0 : 32'(rd));
    check({tag, ".idle_psel"}, 32'(psel), 0);
    check({tag, ".idle_pen"}, 32'(penable), 0);
    @(negedge clk);
    check({tag, ".rsp_pulse"}, 32'(rsp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_strb = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #3;
    check("rst.psel", 32'(psel), 0);
    check("rst.pen", 32'(penable), 0);
    check("rst.paddr", 32'(paddr), 0);
    check("rst.pwrite", 32'(pwrite), 0);
    check("rst.pwdata", 32'(pwdata), 0);
    check("rst.pstrb", 32'(pstrb), 0);
    check("rst.rspv", 32'(rsp_valid), 0);
    check("rst.rdata", 32'(rsp_rdata), 0);
    check("rst.err", 32'(rsp_err), 0);
    @(negedge clk); rst = 1'b0;

    xfer(1'b1, 9'h012, 8'hA5, 1'b1, 0, 8'h00, 1'b0, "wr0");
    xfer(1'b0, 9'h1F0, 8'h00, 1'b0, 3, 8'h3C, 1'b0, "rd_wait");

    // Back-to-back: write then read with req_valid held throughout.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h005; req_wdata = 8'h6E; req_strb = 1'b1;
    #1 check("b2b.ready0", 32'(req_ready), 1);
    @(negedge clk);
    req_write = 1'b0; req_addr = 9'h105; req_wdata = 8'h00; req_strb = 1'b1;
    #1 check("b2b.setup_ready", 32'(req_ready), 0);
    check("b2b.psel1", 32'(psel), 1);
    check("b2b.paddr1", 32'(paddr), 32'h005);
    check("b2b.pstrb1", 32'(pstrb), 1);
    pready = 1'b1; pslverr = 1'b0; prdata = 8'hEE;
    @(negedge clk);
    #1 check("b2b.en_ready", 32'(req_ready), 1);
    check("b2b.en_pen", 32'(penable), 1);
    @(negedge clk);
    req_valid = 1'b0; prdata = 8'h77;
    check("b2b.rsp1", 32'(rsp_valid), 1);
    check("b2b.rdata1", 32'(rsp_rdata), 0);
    check("b2b.psel2", 32'(psel), 2);
    check("b2b.pen2", 32'(penable), 0);
    check("b2b.paddr2", 32'(paddr), 32'h105);
    check("b2b.pwrite2", 32'(pwrite), 0);
    check("b2b.pstrb2", 32'(pstrb), 0);
    @(negedge clk);
    check("b2b.gap", 32'(rsp_valid), 0);
    check("b2b.pen2e", 32'(penable), 1);
    @(negedge clk);
    pready = 1'b0;
    check("b2b.rsp2", 32'(rsp_valid), 1);
    check("b2b.rdata2", 32'(rsp_rdata), 32'h77);
    check("b2b.idle", 32'(psel), 0);

    xfer(1'b1, 9'h0AA, 8'h11, 1'b1, 1, 8'h00, 1'b1, "slverr");
    xfer(1'b0, 9'h0AB, 8'h00, 1'b0, 0, 8'h5A, 1'b0, "post_err");

    // Stuck PREADY: abort on timeout, or wait forever without it.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h1C0; pready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    for (int e = 0; e < TIMEOUT; e++) begin
      @(negedge clk);
      check("to.wait_pen", 32'(penable), 1);
    end
    @(negedge clk);
    check("to.rspv", 32'(rsp_valid), 1);
    check("to.err", 32'(rsp_err), 1);
    check("to.rdata", 32'(rsp_rdata), 0);
    check("to.psel", 32'(psel), 0);
    check("to.pen", 32'(penable), 0);
    check("to.ready", 32'(req_ready), 1);
`else
    repeat (100) @(negedge clk);
    check("stuck.pen", 32'(penable), 1);
    check("stuck.psel", 32'(psel), 2);
    check("stuck.rspv", 32'(rsp_valid), 0);
    prdata = 8'h99; pready = 1'b1;
    @(negedge clk);
    pready = 1'b0;
    check("stuck.rspv_end", 32'(rsp_valid), 1);
    check("stuck.rdata", 32'(rsp_rdata), 32'h99);
    check("stuck.err", 32'(rsp_err), 0);
`endif

    // Reset asserted during an ENABLE wait.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h150; req_wdata = 8'hC3; req_strb = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid.pen_before", 32'(penable), 1);
    #2 rst = 1'b1;
    #1;
    check("mid.psel", 32'(psel), 0);
    check("mid.pen", 32'(penable), 0);
    check("mid.paddr", 32'(paddr), 0);
    check("mid.pwdata", 32'(pwdata), 0);
    check("mid.pstrb", 32'(pstrb), 0);
    check("mid.rspv", 32'(rsp_valid), 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid.no_rsp", 32'(rsp_valid), 0);
    end
    xfer(1'b0, 9'h04D, 8'h00, 1'b0, 2, 8'hB4, 1'b0, "post_rst");

    for (int i = 0; i < 25; i++) begin
      xfer(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom),
           1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), DATA_W'($urandom),
           1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge_n.md
# apb_master_bridge_n

Parametrised APB master bridge: accepts single read/write requests on a valid/ready request port and runs them as APB3/APB4 SETUP/ENABLE transfers. Drives a one-hot PSEL vector for NUM_SLAVES slaves, supports write strobes and back-to-back transfers, and returns read data and error status on a one-cycle response strobe. Sits between the system-side requester and the shared APB slave bus; slave PRDATA/PREADY/PSLVERR are muxed externally onto single inputs.

## Interface
- ADDR_W, 9, address width; slave index is PADDR[ADDR_W-1 -: SEL_W], SEL_W = $clog2(NUM_SLAVES)
- DATA_W, 8, data width; multiple of 8
- NUM_SLAVES, 2, slave count; power of two, ≥2
- TIMEOUT, 16, max consecutive ENABLE wait cycles (used only with timeout compiled in); ≥2
- One clock; reset is asynchronous and active-high.
- PCLK  in  1  APB clock; all logic on rising edge
- PRESET  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted on this edge when both high
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  write byte strobes
- rsp_valid  out  1  one-cycle response strobe; no backpressure
- rsp_rdata  out  DATA_W  read data (0 for writes and aborts)
- rsp_err  out  1  PSLVERR or timeout
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB access phase
- PADDR  out  ADDR_W  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PSTRB  out  DATA_W/8  APB strobes; 0 on reads
- PRDATA  in  DATA_W  selected slave read data
- PREADY  in  1  selected slave ready
- PSLVERR  in  1  selected slave error

## Operation
- States: IDLE, SETUP, ENABLE.
- req_ready = (state==IDLE) || (state==ENABLE && PREADY); combinational.
- Accept (req_valid && req_ready): register addr/write/wdata/strb onto PADDR/PWRITE/PWDATA/PSTRB (PSTRB forced 0 if read); next state SETUP.
- IDLE: PSEL=0, PENABLE=0; stay until accept.
- SETUP: PSEL[idx]=1, PENABLE=0; unconditionally → ENABLE next edge.
- ENABLE: PSEL held, PENABLE=1. PREADY=0 → stay, all APB outputs stable. PREADY=1 → transfer completes: capture PRDATA (reads) and PSLVERR; → SETUP if new request accepted same edge, else → IDLE.
- Completion response: rsp_valid=1 for one cycle after completion edge; rsp_err=PSLVERR sampled; rsp_rdata=PRDATA for reads, 0 for writes.
- PADDR/PWRITE/PWDATA/PSTRB hold last value in IDLE; change only on accept.
- req inputs ignored whenever req_ready=0.

## Timing
- Reset (async assert, sync-safe release): state IDLE; PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err all 0; timeout counter 0.
- Reset mid-transfer: bus outputs drop to 0 immediately; no response issued for aborted transfer.
- Zero-wait latency: accept edge T0; SETUP cycle T0+1; ENABLE T0+2 with PREADY=1; rsp_valid during T0+3.
- Back-to-back: accept at completion edge gives ENABLE→SETUP with no IDLE cycle; sustained throughput one transfer per 2 cycles; PSEL may switch slave at that SETUP.
- Each wait state (PREADY=0 in ENABLE) adds one cycle.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: counter increments each ENABLE cycle with PREADY=0, clears on entering SETUP. When PREADY=0 for TIMEOUT consecutive ENABLE cycles, transfer aborts at that edge: → IDLE, PSEL/PENABLE=0 next cycle, rsp_valid=1, rsp_err=1, rsp_rdata=0; req_ready stays 0 on the abort edge. PREADY=1 on the TIMEOUT-th cycle completes normally.
- Undefined: no counter; ENABLE waits indefinitely for PREADY.

## Test plan
- Reset then write addr 0x012, data 0xA5, strb 1, PREADY=1 → PSEL=01, PENABLE high cycle 2, PSTRB=1, rsp_valid cycle 3, rsp_err=0, rsp_rdata=0.
- Read addr 0x1F0, PRDATA=0x3C, PREADY low 3 ENABLE cycles → PSEL=10, outputs stable during waits, rsp_rdata=0x3C 1 cycle after PREADY.
- req_valid held with write 0x005 then read 0x105 → no IDLE between, PSEL 01→10 at second SETUP, PSTRB 0 on read, two rsp_valid pulses 2 cycles apart.
- Write with PSLVERR=1 at completion → rsp_err=1; next transfer unaffected, rsp_err=0.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT=16, PREADY stuck 0 → abort after 16 ENABLE cycles, rsp_err=1, rsp_rdata=0, PSEL=0, state IDLE; without macro, still in ENABLE after 100 cycles.
- Assert PRESET during ENABLE wait → all outputs 0 asynchronously, no rsp_valid; new request after release completes normally.
